cnn_layer_sequencer: RTL and testbench

CNN_LAYER_SEQUENCER -- requirements
Module: cnn_layer_sequencer

---
 rtl/cnn_pkg.sv | 13 +
 rtl/cnn_layer_sequencer_watchdog.sv | 21 ++
 rtl/cnn_layer_sequencer.sv | 112 +++++++++++
 tb/tb_cnn_layer_sequencer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// cnn_pkg: shared FSM states, stage indices and defaults for the CNN layer sequencer
package cnn_pkg;
  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT, S_FINISH, S_ERROR} seq_state_t;
  localparam int STG_CONV1    = 0;
  localparam int STG_POOL1    = 1;
  localparam int STG_CONV2    = 2;
  localparam int STG_POOL2    = 3;
  localparam int STG_CONV3    = 4;
  localparam int STG_POOL3    = 5;
  localparam int STG_DENSE0   = 6;
  localparam int STG_DENSE1   = 7;
  localparam int N_STAGES_DEF = 8;
endpackage

// File: rtl/cnn_layer_sequencer_watchdog.sv
// seq_watchdog: per-stage WAIT cycle counter for the sequencer timeout (built only with SEQ_TIMEOUT_EN)
// Ports: clk, resetn (async active-low), i_clear (zero the count), i_inc (count one WAIT cycle),
//        o_expired (this WAIT cycle is the TIMEOUT_CYCLES-th one).
`ifdef SEQ_TIMEOUT_EN
module seq_watchdog #(
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic clk,
  input  logic resetn,
  input  logic i_clear,
  input  logic i_inc,
  output logic o_expired
);
  logic [15:0] r_cnt;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) r_cnt <= '0;
    else if (i_clear) r_cnt <= '0;
    else if (i_inc) r_cnt <= r_cnt + 16'd1;
  assign o_expired = i_inc && (r_cnt == 16'(TIMEOUT_CYCLES - 1));
endmodule
`endif

// File: rtl/cnn_layer_sequencer.sv
// cnn_layer_sequencer: launches N_STAGES layer stages in order, one frame per i_start
// Ports: clk, resetn (async active-low), i_start, i_abort, i_stage_done[N_STAGES],
//        o_stage_start[N_STAGES] (one-hot pulse), o_stage_idx, o_busy, o_done, o_error, o_frame_cnt.
// Macro SEQ_TIMEOUT_EN: adds a per-stage WAIT timeout leading to a sticky ERROR state.
module cnn_layer_sequencer
  import cnn_pkg::*;
#(
  parameter int N_STAGES       = N_STAGES_DEF,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int FRAME_CNT_W    = 16
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   i_start,
  input  logic                   i_abort,
  input  logic [N_STAGES-1:0]    i_stage_done,
  output logic [N_STAGES-1:0]    o_stage_start,
  output logic [3:0]             o_stage_idx,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_error,
  output logic [FRAME_CNT_W-1:0] o_frame_cnt
);
  localparam logic [N_STAGES-1:0] ONE  = {{(N_STAGES-1){1'b0}}, 1'b1};
  localparam logic [3:0]          LAST = 4'(N_STAGES - 1);
  seq_state_t              r_state;
  logic [3:0]              r_idx;
  logic [N_STAGES-1:0]     r_start;
  logic                    r_busy;
  logic                    r_done;
  logic [FRAME_CNT_W-1:0]  r_frame;
  logic                    w_hit;
  // only the done bit of the active stage can advance the sequence
  assign w_hit = |(i_stage_done & (ONE << r_idx));
`ifdef SEQ_TIMEOUT_EN
  logic r_err;
  logic w_expired;
  seq_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
    .clk       (clk),
    .resetn    (resetn),
    .i_clear   (r_state == S_LAUNCH),
    .i_inc     (r_state == S_WAIT),
    .o_expired (w_expired)
  );
  assign o_error = r_err;
`else
  assign o_error = 1'b0;
`endif
  // outputs are registered together with the state they belong to
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_start <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_frame <= '0;
`ifdef SEQ_TIMEOUT_EN
      r_err   <= 1'b0;
`endif
    end else begin
      r_start <= '0;
      r_done  <= 1'b0;
      if (i_abort) begin
        r_state <= S_IDLE;
        r_idx   <= '0;
        r_busy  <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
        r_err   <= 1'b0;
`endif
      end else
        case (r_state)
          S_IDLE:
            if (i_start) begin
              r_state <= S_LAUNCH;
              r_idx   <= '0;
              r_busy  <= 1'b1;
              r_start <= ONE;
            end
          S_LAUNCH: r_state <= S_WAIT;
          S_WAIT:
            if (w_hit) begin
              if (r_idx == LAST) begin
                r_state <= S_FINISH;
                r_done  <= 1'b1;
                r_frame <= r_frame + FRAME_CNT_W'(1);
              end else begin
                r_state <= S_LAUNCH;
                r_idx   <= r_idx + 4'd1;
                r_start <= ONE << (r_idx + 4'd1);
              end
            end
`ifdef SEQ_TIMEOUT_EN
            else if (w_expired) begin
              r_state <= S_ERROR;
              r_err   <= 1'b1;
            end
          S_ERROR: r_state <= S_ERROR;
`endif
          default: begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_busy  <= 1'b0;
          end
        endcase
    end
  assign o_stage_start = r_start;
  assign o_stage_idx   = r_idx;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_frame_cnt   = r_frame;
endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// tb_cnn_layer_sequencer: scoreboard bench for the CNN layer sequencer
module tb_cnn_layer_sequencer;
  logic       clk = 0;
  logic       resetn = 0;
  logic       i_start = 0;
  logic       i_abort = 0;
  logic [7:0] i_stage_done = 0;
  logic [7:0] o_stage_start;
  logic [3:0] o_stage_idx;
  logic       o_busy, o_done, o_error;
  logic [1:0] o_frame_cnt;
  typedef struct {int val; int cyc;} exp_t;
  exp_t sq[$];
  exp_t dq[$];
  int tests = 0, fails = 0, cyc = 0;
  logic [1:0] m_cnt = 0;

  cnn_layer_sequencer #(.N_STAGES(8), .TIMEOUT_CYCLES(10), .FRAME_CNT_W(2)) dut (
    .clk(clk), .resetn(resetn), .i_start(i_start), .i_abort(i_abort),
    .i_stage_done(i_stage_done), .o_stage_start(o_stage_start), .o_stage_idx(o_stage_idx),
    .o_busy(o_busy), .o_done(o_done), .o_error(o_error), .o_frame_cnt(o_frame_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (resetn) begin
      if (o_stage_start != 0) begin
        exp_t e;
        tests++;
        if (sq.size() == 0) begin
          fails++;
          $display("FAIL unexpected_start: got start=%b idx=%0d, none expected", o_stage_start, o_stage_idx);
        end else begin
          e = sq.pop_front();
          if (o_stage_start != (8'd1 << e.val) || o_stage_idx != 4'(e.val) || cyc != e.cyc) begin
            fails++;
            $display("FAIL start_pulse: got start=%b idx=%0d cyc=%0d, expected stage %0d at cyc %0d",
                     o_stage_start, o_stage_idx, cyc, e.val, e.cyc);
          end
        end
      end
      if (o_done) begin
        exp_t e;
        tests++;
        if (dq.size() == 0) begin
          fails++;
          $display("FAIL unexpected_done: got done with cnt=%0d, none expected", o_frame_cnt);
        end else begin
          e = dq.pop_front();
          if (o_frame_cnt != 2'(e.val) || cyc != e.cyc) begin
            fails++;
            $display("FAIL done_pulse: got cnt=%0d cyc=%0d, expected cnt=%0d cyc=%0d",
                     o_frame_cnt, cyc, e.val, e.cyc);
          end
        end
      end
    end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_start(input int k);
    for (int w = 0; w < 20 && !o_stage_start[k]; w++) tick;
    chk($sformatf("start_seen_%0d", k), 32'(o_stage_start[k]), 1);
  endtask

  // mode 0 normal, 1 stray done at stage `at`, 2 abort at `at`, 3 reset at `at`
  task automatic run_frame(input int mode, input int at, input bit hold);
    sq.push_back('{0, cyc + 1});
    i_start = 1;
    tick;
    if (!hold) i_start = 0;
    for (int k = 0; k < 8; k++) begin
      wait_start(k);
      if (k == at && mode == 1) begin
        tick;
        i_stage_done = 8'h20;
        tick;
        i_stage_done = 0;
        chk("stray_idx", 32'(o_stage_idx), 32'(at));
        chk("stray_start", 32'(o_stage_start), 0);
      end
      if (k == at && mode == 2) begin
        tick;
        i_abort = 1;
        i_stage_done = 8'd1 << k;
        tick;
        i_abort = 0;
        i_stage_done = 0;
        chk("abort_busy", 32'(o_busy), 0);
        chk("abort_idx", 32'(o_stage_idx), 0);
        chk("abort_done", 32'(o_done), 0);
        chk("abort_cnt", 32'(o_frame_cnt), 32'(m_cnt));
        tick;
        chk("abort_done2", 32'(o_done), 0);
        return;
      end
      if (k == at && mode == 3) begin
        tick;
        #1 resetn = 0;
        #1;
        chk("rst_start", 32'(o_stage_start), 0);
        chk("rst_idx", 32'(o_stage_idx), 0);
        chk("rst_busy", 32'(o_busy), 0);
        chk("rst_cnt", 32'(o_frame_cnt), 0);
        sq.delete();
        dq.delete();
        m_cnt = 0;
        #2 resetn = 1;
        return;
      end
      repeat (3) tick;
      if (k < 7) sq.push_back('{k + 1, cyc + 1});
      else begin
        m_cnt++;
        dq.push_back('{int'(m_cnt), cyc + 1});
        i_start = 0;
      end
      i_stage_done = 8'd1 << k;
      tick;
      i_stage_done = 0;
    end
    tick;
    chk("frame_end_busy", 32'(o_busy), 0);
    chk("frame_end_idx", 32'(o_stage_idx), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    repeat (3) tick;
    chk("reset_start", 32'(o_stage_start), 0);
    chk("reset_idx", 32'(o_stage_idx), 0);
    chk("reset_busy", 32'(o_busy), 0);
    chk("reset_done", 32'(o_done), 0);
    chk("reset_error", 32'(o_error), 0);
    chk("reset_cnt", 32'(o_frame_cnt), 0);
    #3 resetn = 1;
    tick;
    run_frame(0, -1, 0);
    chk("full_frame_cnt", 32'(o_frame_cnt), 1);
    run_frame(1, 2, 0);
    chk("stray_frame_cnt", 32'(o_frame_cnt), 2);
    run_frame(2, 4, 0);
    tick;
    // timeout on stage 1
    sq.push_back('{0, cyc + 1});
    i_start = 1;
    tick;
    i_start = 0;
    wait_start(0);
    repeat (3) tick;
    sq.push_back('{1, cyc + 1});
    i_stage_done = 8'h01;
    tick;
    i_stage_done = 0;
    wait_start(1);
`ifdef SEQ_TIMEOUT_EN
    repeat (10) tick;
    chk("to_err_early", 32'(o_error), 0);
    tick;
    chk("to_err", 32'(o_error), 1);
    chk("to_busy", 32'(o_busy), 1);
`else
    repeat (30) tick;
    chk("noto_err", 32'(o_error), 0);
    chk("noto_busy", 32'(o_busy), 1);
    chk("noto_idx", 32'(o_stage_idx), 1);
`endif
    i_abort = 1;
    tick;
    i_abort = 0;
    chk("to_abort_err", 32'(o_error), 0);
    chk("to_abort_busy", 32'(o_busy), 0);
    chk("to_abort_idx", 32'(o_stage_idx), 0);
    chk("to_abort_cnt", 32'(o_frame_cnt), 2);
    run_frame(3, 6, 0);
    tick;
    run_frame(0, -1, 0);
    chk("post_reset_cnt", 32'(o_frame_cnt), 1);
    #3 resetn = 0;
    m_cnt = 0;
    #3 resetn = 1;
    tick;
    for (int f = 0; f < 5; f++) run_frame(0, -1, 1);
    chk("wrap_cnt", 32'(o_frame_cnt), 1);
    repeat (4) tick;
    chk("start_q_empty", 32'(sq.size()), 0);
    chk("done_q_empty", 32'(dq.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
